// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with forwarding, EX/MEM register and iterative mul/div.
// Define EX_MULDIV_EN to build the multiply/divide unit, HI/LO and stall logic.

module ALU (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [5:0]  ALUFun,
    input  logic        Sign,
    output logic [31:0] Z
);
    logic lt;

    always_comb begin
        lt = Sign ? ($signed(A) < $signed(B)) : (A < B);
        Z  = '0;
        case (ALUFun)
            6'b000000: Z = A + B;
            6'b000001: Z = A - B;
            6'b011000: Z = A & B;
            6'b011110: Z = A | B;
            6'b010110: Z = A ^ B;
            6'b010001: Z = ~(A | B);
            6'b011010: Z = A;
            6'b100000: Z = B << A[4:0];
            6'b100001: Z = B >> A[4:0];
            6'b100011: Z = $signed(B) >>> A[4:0];
            6'b110011: Z = {31'd0, A == B};
            6'b110001: Z = {31'd0, A != B};
            6'b110101: Z = {31'd0, lt};
            6'b111101: Z = {31'd0, $signed(A) <= 0};
            6'b111011: Z = {31'd0, A[31]};
            6'b111111: Z = {31'd0, $signed(A) > 0};
            default:   Z = '0;
        endcase
    end
endmodule

module ex_stage_md #(
    parameter int          MD_STEP   = 1,
    parameter logic [31:0] HI_LO_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic        flush,
    input  logic [4:0]  Shamt,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] DatabusA,
    input  logic [31:0] DatabusB,
    input  logic [31:0] Ext_out,
    input  logic [31:0] LU_out,
    input  logic [31:0] PC,
    input  logic        ALUSrc1,
    input  logic        ALUSrc2,
    input  logic        Sign,
    input  logic        Branch,
    input  logic [5:0]  ALUFun,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemToReg,
    input  logic [3:0]  md_op,
    input  logic        mem_RegWrite,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] MEM_ALU_out,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] WB_DatabusC,
    output logic        EX_Branch_EN,
    output logic [31:0] ConBA,
    output logic        ex_stall,
    output logic        exmem_valid,
    output logic        exmem_RegWrite,
    output logic        exmem_MemRead,
    output logic        exmem_MemWrite,
    output logic [1:0]  exmem_MemToReg,
    output logic [4:0]  exmem_rd,
    output logic [31:0] exmem_alu_out,
    output logic [31:0] exmem_store_data,
    output logic [31:0] exmem_pc_plus_4
);
    logic [31:0] rs_fwd;
    logic [31:0] rt_fwd;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_z;
    logic [31:0] ex_result;
    logic        accept;

    // MEM beats WB beats the register file; r0 is never forwarded
    always_comb begin
        if (mem_RegWrite && mem_rd != 5'd0 && mem_rd == rs_addr)
            rs_fwd = MEM_ALU_out;
        else if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == rs_addr)
            rs_fwd = WB_DatabusC;
        else
            rs_fwd = DatabusA;
        if (mem_RegWrite && mem_rd != 5'd0 && mem_rd == rt_addr)
            rt_fwd = MEM_ALU_out;
        else if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == rt_addr)
            rt_fwd = WB_DatabusC;
        else
            rt_fwd = DatabusB;
    end

    assign alu_in1 = ALUSrc1 ? {27'd0, Shamt} : rs_fwd;
    assign alu_in2 = ALUSrc2 ? LU_out : rt_fwd;

    ALU u_alu (
        .A      (alu_in1),
        .B      (alu_in2),
        .ALUFun (ALUFun),
        .Sign   (Sign),
        .Z      (alu_z)
    );

    assign ConBA        = PC + 32'd4 + (Ext_out << 2);
    assign EX_Branch_EN = id_valid & Branch & alu_z[0] & ~ex_stall;
    assign accept       = id_valid & ~flush & ~ex_stall;

`ifdef EX_MULDIV_EN
    localparam int         N        = 32 / MD_STEP;
    localparam logic [4:0] CNT_LAST = 5'(N - 1);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t              state;
    logic [4:0]             cnt;
    logic [31:0]            hi;
    logic [31:0]            lo;
    logic [31:0]            acc_hi;
    logic [31:0]            acc_lo;
    logic [31:0]            opb;
    logic [31:0]            dividend;
    logic                   is_div;
    logic                   neg_q;
    logic                   neg_r;
    logic                   div_zero;
    logic                   md_req;
    logic                   md_start;
    logic                   signed_op;
    logic [31:0]            abs_a;
    logic [31:0]            abs_b;
    logic [31+MD_STEP:0]    mul_sum;
    logic [32:0]            dv_t;
    logic [31:0]            dv_r;
    logic [31:0]            dv_q;
    logic [31:0]            step_hi;
    logic [31:0]            step_lo;
    logic [63:0]            mul_fin;
    logic [31:0]            div_q;
    logic [31:0]            div_r;

    assign md_req    = (md_op >= 4'd1) && (md_op <= 4'd8);
    assign ex_stall  = id_valid & ~flush & (state == BUSY) & md_req;
    assign md_start  = accept && (md_op >= 4'd1) && (md_op <= 4'd4);
    assign signed_op = (md_op == 4'd1) || (md_op == 4'd3);
    assign abs_a     = (signed_op && rs_fwd[31]) ? -rs_fwd : rs_fwd;
    assign abs_b     = (signed_op && rt_fwd[31]) ? -rt_fwd : rt_fwd;

    // One iteration: MD_STEP shift-add bits or MD_STEP restoring-divide bits
    always_comb begin
        mul_sum = {{MD_STEP{1'b0}}, acc_hi}
                + {{MD_STEP{1'b0}}, opb} * (32+MD_STEP)'(acc_lo[MD_STEP-1:0]);
        dv_r = acc_hi;
        dv_q = acc_lo;
        dv_t = '0;
        for (int i = 0; i < MD_STEP; i++) begin
            dv_t = {dv_r, dv_q[31]};
            dv_q = {dv_q[30:0], 1'b0};
            if (dv_t >= {1'b0, opb}) begin
                dv_t    = dv_t - {1'b0, opb};
                dv_q[0] = 1'b1;
            end
            dv_r = dv_t[31:0];
        end
        if (is_div) begin
            step_hi = dv_r;
            step_lo = dv_q;
        end else begin
            step_hi = mul_sum[31+MD_STEP:MD_STEP];
            step_lo = {mul_sum[MD_STEP-1:0], acc_lo[31:MD_STEP]};
        end
        mul_fin = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        div_q   = div_zero ? 32'hFFFF_FFFF : (neg_q ? -step_lo : step_lo);
        div_r   = div_zero ? dividend : (neg_r ? -step_hi : step_hi);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= HI_LO_RST;
            lo       <= HI_LO_RST;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            dividend <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (md_start) begin
                        is_div   <= md_op[2] | (md_op[1] & md_op[0]);
                        neg_q    <= signed_op & (rs_fwd[31] ^ rt_fwd[31]);
                        neg_r    <= signed_op & rs_fwd[31];
                        div_zero <= (rt_fwd == 32'd0);
                        dividend <= rs_fwd;
                        acc_hi   <= '0;
                        if (md_op[2] | (md_op[1] & md_op[0])) begin
                            acc_lo <= abs_a;
                            opb    <= abs_b;
                        end else begin
                            acc_lo <= abs_b;
                            opb    <= abs_a;
                        end
                        cnt   <= CNT_LAST;
                        state <= BUSY;
                    end else if (accept && md_op == 4'd7) begin
                        hi <= rs_fwd;
                    end else if (accept && md_op == 4'd8) begin
                        lo <= rs_fwd;
                    end
                end
                BUSY: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (is_div) begin
                            hi <= div_r;
                            lo <= div_q;
                        end else begin
                            hi <= mul_fin[63:32];
                            lo <= mul_fin[31:0];
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        if (md_op == 4'd5)
            ex_result = hi;
        else if (md_op == 4'd6)
            ex_result = lo;
        else
            ex_result = alu_z;
    end
`else
    logic [31:0] unused_cfg;

    assign unused_cfg = HI_LO_RST ^ 32'(MD_STEP);
    assign ex_stall   = 1'b0;

    always_comb begin
        if (md_op == 4'd5 || md_op == 4'd6)
            ex_result = '0;
        else
            ex_result = alu_z;
    end
`endif

    // Stalled, flushed or invalid slots all enter MEM as an all-zero bubble
    always_ff @(posedge clk) begin
        if (reset || !accept) begin
            exmem_valid      <= 1'b0;
            exmem_RegWrite   <= 1'b0;
            exmem_MemRead    <= 1'b0;
            exmem_MemWrite   <= 1'b0;
            exmem_MemToReg   <= '0;
            exmem_rd         <= '0;
            exmem_alu_out    <= '0;
            exmem_store_data <= '0;
            exmem_pc_plus_4  <= '0;
        end else begin
            exmem_valid      <= 1'b1;
            exmem_RegWrite   <= RegWrite;
            exmem_MemRead    <= MemRead;
            exmem_MemWrite   <= MemWrite;
            exmem_MemToReg   <= MemToReg;
            exmem_rd         <= rd_addr;
            exmem_alu_out    <= ex_result;
            exmem_store_data <= rt_fwd;
            exmem_pc_plus_4  <= PC + 32'd4;
        end
    end
endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed and randomized checks of ex_stage_md
// against a behavioural model of forwarding, ALU, branch and mul/div.

module tb_ex_stage_md;
    localparam int MD_STEP = 1;
    localparam int N       = 32 / MD_STEP;

    localparam logic [5:0] F_ADD = 6'b000000;
    localparam logic [5:0] F_SUB = 6'b000001;
    localparam logic [5:0] F_AND = 6'b011000;
    localparam logic [5:0] F_OR  = 6'b011110;
    localparam logic [5:0] F_XOR = 6'b010110;
    localparam logic [5:0] F_NOR = 6'b010001;
    localparam logic [5:0] F_A   = 6'b011010;
    localparam logic [5:0] F_SLL = 6'b100000;
    localparam logic [5:0] F_SRL = 6'b100001;
    localparam logic [5:0] F_SRA = 6'b100011;
    localparam logic [5:0] F_EQ  = 6'b110011;
    localparam logic [5:0] F_NEQ = 6'b110001;
    localparam logic [5:0] F_LT  = 6'b110101;
    localparam logic [5:0] F_LEZ = 6'b111101;
    localparam logic [5:0] F_LTZ = 6'b111011;
    localparam logic [5:0] F_GTZ = 6'b111111;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, flush;
    logic [4:0]  Shamt, rs_addr, rt_addr, rd_addr;
    logic [31:0] DatabusA, DatabusB, Ext_out, LU_out, PC;
    logic        ALUSrc1, ALUSrc2, Sign, Branch;
    logic [5:0]  ALUFun;
    logic        RegWrite, MemRead, MemWrite;
    logic [1:0]  MemToReg;
    logic [3:0]  md_op;
    logic        mem_RegWrite, wb_RegWrite;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] MEM_ALU_out, WB_DatabusC;
    logic        EX_Branch_EN, ex_stall;
    logic [31:0] ConBA;
    logic        exmem_valid, exmem_RegWrite, exmem_MemRead, exmem_MemWrite;
    logic [1:0]  exmem_MemToReg;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_alu_out, exmem_store_data, exmem_pc_plus_4;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ex_stage_md #(.MD_STEP(MD_STEP), .HI_LO_RST(32'h0)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .flush(flush),
        .Shamt(Shamt), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .DatabusA(DatabusA), .DatabusB(DatabusB), .Ext_out(Ext_out),
        .LU_out(LU_out), .PC(PC), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
        .Sign(Sign), .Branch(Branch), .ALUFun(ALUFun), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .md_op(md_op), .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd),
        .MEM_ALU_out(MEM_ALU_out), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
        .WB_DatabusC(WB_DatabusC), .EX_Branch_EN(EX_Branch_EN), .ConBA(ConBA),
        .ex_stall(ex_stall), .exmem_valid(exmem_valid),
        .exmem_RegWrite(exmem_RegWrite), .exmem_MemRead(exmem_MemRead),
        .exmem_MemWrite(exmem_MemWrite), .exmem_MemToReg(exmem_MemToReg),
        .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
        .exmem_store_data(exmem_store_data), .exmem_pc_plus_4(exmem_pc_plus_4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_valid = 0; flush = 0; Shamt = 0; rs_addr = 0; rt_addr = 0; rd_addr = 0;
        DatabusA = 0; DatabusB = 0; Ext_out = 0; LU_out = 0; PC = 0;
        ALUSrc1 = 0; ALUSrc2 = 0; Sign = 0; Branch = 0; ALUFun = F_ADD;
        RegWrite = 0; MemRead = 0; MemWrite = 0; MemToReg = 0; md_op = 0;
        mem_RegWrite = 0; mem_rd = 0; MEM_ALU_out = 0;
        wb_RegWrite = 0; wb_rd = 0; WB_DatabusC = 0;
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rf);
        if (mem_RegWrite && mem_rd != 0 && mem_rd == src) return MEM_ALU_out;
        if (wb_RegWrite && wb_rd != 0 && wb_rd == src) return WB_DatabusC;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic s);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f)
            F_ADD: return a + b;
            F_SUB: return a - b;
            F_AND: return a & b;
            F_OR:  return a | b;
            F_XOR: return a ^ b;
            F_NOR: return ~(a | b);
            F_A:   return a;
            F_SLL: return b << a[4:0];
            F_SRL: return b >> a[4:0];
            F_SRA: return 32'(sb >>> a[4:0]);
            F_EQ:  return 32'(a == b);
            F_NEQ: return 32'(a != b);
            F_LT:  return s ? 32'(sa < sb) : 32'(a < b);
            F_LEZ: return 32'(sa <= 0);
            F_LTZ: return 32'(sa < 0);
            F_GTZ: return 32'(sa > 0);
            default: return 32'd0;
        endcase
    endfunction

`ifdef EX_MULDIV_EN
    logic [31:0] last_lo;

    task automatic md_check(input string tag, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh;
        logic [31:0] el;
        longint p;
        int sa;
        int sb;
        int cyc;
        sa = a;
        sb = b;
        eh = 0;
        el = 0;
        if (op == 4'd1) begin
            p = longint'(sa) * longint'(sb);
            {eh, el} = p;
        end else if (op == 4'd2) begin
            p = longint'({32'd0, a}) * longint'({32'd0, b});
            {eh, el} = p;
        end else if (b == 0) begin
            el = 32'hFFFF_FFFF;
            eh = a;
        end else if (op == 4'd3) begin
            el = 32'(sa / sb);
            eh = 32'(sa % sb);
        end else begin
            el = a / b;
            eh = a % b;
        end
        idle_in();
        id_valid = 1; md_op = op; rs_addr = 1; rt_addr = 2; DatabusA = a; DatabusB = b;
        tick();
        md_op = 4'd5; rs_addr = 0; rt_addr = 0; rd_addr = 3; RegWrite = 1;
        #1;
        cyc = 0;
        while (ex_stall === 1'b1 && cyc < 4 * N) begin
            tick();
            cyc++;
            if (cyc == 1) chk({tag, "_bubble"}, 32'(exmem_valid), 32'd0);
        end
        chk({tag, "_stall_cycles"}, 32'(cyc), 32'(N));
        tick();
        chk({tag, "_hi"}, exmem_alu_out, eh);
        md_op = 4'd6;
        tick();
        chk({tag, "_lo"}, exmem_alu_out, el);
        last_lo = el;
        idle_in();
    endtask
`endif

    initial begin
        logic [5:0]  ops [16];
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_z;
        logic [31:0] exp_st;
        logic [10:0] exp_ctl;

        ops = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_A, F_SLL,
                F_SRL, F_SRA, F_EQ, F_NEQ, F_LT, F_LEZ, F_LTZ, F_GTZ};

        idle_in();
        reset = 1;
        repeat (2) tick();
        chk("rst_valid", 32'(exmem_valid), 32'd0);
        chk("rst_alu", exmem_alu_out, 32'd0);
        chk("rst_stall", 32'(ex_stall), 32'd0);
        reset = 0;

        id_valid = 1; rs_addr = 5; rt_addr = 6; rd_addr = 7; RegWrite = 1;
        mem_RegWrite = 1; mem_rd = 5; MEM_ALU_out = 32'h11;
        wb_RegWrite = 1; wb_rd = 5; WB_DatabusC = 32'h22;
        DatabusA = 32'h33; DatabusB = 32'h1; PC = 32'h40;
        tick();
        chk("fwd_mem", exmem_alu_out, 32'h12);
        chk("fwd_valid", 32'(exmem_valid), 32'd1);
        chk("fwd_rd", 32'(exmem_rd), 32'd7);
        chk("fwd_pc4", exmem_pc_plus_4, 32'h44);
        mem_RegWrite = 0;
        tick();
        chk("fwd_wb", exmem_alu_out, 32'h23);
        rs_addr = 0; mem_RegWrite = 1; mem_rd = 0; wb_rd = 0;
        tick();
        chk("fwd_r0", exmem_alu_out, 32'h34);
        rs_addr = 5; rt_addr = 5; mem_rd = 5;
        tick();
        chk("fwd_rt_store", exmem_store_data, 32'h11);

        for (int i = 0; i < 40; i++) begin
            id_valid = 1; flush = 0; md_op = 0;
            rs_addr = 5'($urandom_range(0, 3)); rt_addr = 5'($urandom_range(0, 3));
            rd_addr = 5'($urandom); mem_RegWrite = 1'($urandom);
            mem_rd = 5'($urandom_range(0, 3)); wb_RegWrite = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 3)); MEM_ALU_out = $urandom;
            WB_DatabusC = $urandom; DatabusA = $urandom; DatabusB = $urandom;
            ALUSrc1 = 1'($urandom); ALUSrc2 = 1'($urandom); Sign = 1'($urandom);
            Shamt = 5'($urandom); LU_out = $urandom;
            ALUFun = ops[$urandom_range(0, 15)];
            Branch = 1'($urandom); PC = $urandom & 32'hFFFF_FFFC; Ext_out = $urandom;
            RegWrite = 1'($urandom); MemRead = 1'($urandom);
            MemWrite = 1'($urandom); MemToReg = 2'($urandom);
            a = ALUSrc1 ? {27'd0, Shamt} : ref_fwd(rs_addr, DatabusA);
            b = ALUSrc2 ? LU_out : ref_fwd(rt_addr, DatabusB);
            exp_z = ref_alu(ALUFun, a, b, Sign);
            exp_st = ref_fwd(rt_addr, DatabusB);
            exp_ctl = {1'b1, RegWrite, MemRead, MemWrite, MemToReg, rd_addr};
            #1;
            chk("rnd_branch_en", 32'(EX_Branch_EN), 32'(Branch & exp_z[0]));
            chk("rnd_conba", ConBA, PC + 32'd4 + Ext_out * 32'd4);
            tick();
            chk("rnd_alu", exmem_alu_out, exp_z);
            chk("rnd_store", exmem_store_data, exp_st);
            chk("rnd_ctl", 32'({exmem_valid, exmem_RegWrite, exmem_MemRead,
                                exmem_MemWrite, exmem_MemToReg, exmem_rd}), 32'(exp_ctl));
        end

        idle_in();
        id_valid = 1; PC = 32'h100; Ext_out = 32'hFFFF_FFFE; Branch = 1; ALUFun = F_EQ;
        rs_addr = 1; rt_addr = 2; DatabusA = 32'h7; DatabusB = 32'h7;
        #1;
        chk("br_en", 32'(EX_Branch_EN), 32'd1);
        chk("br_conba", ConBA, 32'hFC);
        tick();
        chk("br_valid", 32'(exmem_valid), 32'd1);
        flush = 1; RegWrite = 1;
        tick();
        chk("br_flush_valid", 32'(exmem_valid), 32'd0);
        chk("br_flush_regwr", 32'(exmem_RegWrite), 32'd0);
        flush = 0; id_valid = 0;
        #1;
        chk("br_invalid_en", 32'(EX_Branch_EN), 32'd0);
        tick();
        chk("bubble_valid", 32'(exmem_valid), 32'd0);

`ifdef EX_MULDIV_EN
        md_check("mult_neg", 4'd1, 32'hFFFF_FFFF, 32'd3);
        md_check("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2);
        md_check("divu_zero", 4'd4, 32'd9, 32'd0);
        md_check("div_zero_neg", 4'd3, 32'hFFFF_FF00, 32'd0);
        for (int i = 0; i < 8; i++) begin
            logic [3:0]  op;
            logic [31:0] ra;
            logic [31:0] rb;
            op = 4'($urandom_range(1, 4));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
            if (op == 4'd3 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            md_check("md_rnd", op, ra, rb);
        end

        idle_in();
        id_valid = 1; md_op = 4'd7; rs_addr = 4; DatabusA = 32'hCAFE_0001;
        tick();
        md_op = 4'd8; flush = 1; DatabusA = 32'h1234;
        tick();
        flush = 0; md_op = 4'd5;
        tick();
        chk("mthi", exmem_alu_out, 32'hCAFE_0001);
        md_op = 4'd6;
        tick();
        chk("mtlo_flushed", exmem_alu_out, last_lo);
        md_op = 4'd8; mem_RegWrite = 1; mem_rd = 4; MEM_ALU_out = 32'h5555;
        tick();
        md_op = 4'd6; mem_RegWrite = 0;
        tick();
        chk("mtlo_fwd", exmem_alu_out, 32'h5555);
`else
        idle_in();
        id_valid = 1; md_op = 4'd1; rs_addr = 1; DatabusA = 32'h5; DatabusB = 32'h3;
        tick();
        md_op = 4'd5;
        #1;
        chk("nomd_stall", 32'(ex_stall), 32'd0);
        tick();
        chk("nomd_mfhi", exmem_alu_out, 32'd0);
        chk("nomd_valid", 32'(exmem_valid), 32'd1);
`endif

        idle_in();
        id_valid = 1; md_op = 4'd4; rs_addr = 1; rt_addr = 2;
        DatabusA = 32'd100; DatabusB = 32'd7;
        tick();
        md_op = 4'd0; ALUFun = F_ADD; RegWrite = 1; MemWrite = 1; MemToReg = 2'd2;
        rd_addr = 9; PC = 32'h80;
        repeat (4) tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst_mid_valid", 32'(exmem_valid), 32'd0);
        chk("rst_mid_ctl", 32'({exmem_RegWrite, exmem_MemRead, exmem_MemWrite,
                                exmem_MemToReg, exmem_rd}), 32'd0);
        chk("rst_mid_data", exmem_alu_out | exmem_store_data | exmem_pc_plus_4, 32'd0);
        md_op = 4'd6; RegWrite = 0; MemWrite = 0; MemToReg = 0;
        #1;
        chk("rst_mid_stall", 32'(ex_stall), 32'd0);
        tick();
        chk("rst_mid_mflo", exmem_alu_out, 32'd0);
        chk("rst_mid_mflo_valid", 32'(exmem_valid), 32'd1);
        md_op = 4'd5;
        tick();
        chk("rst_mid_mfhi", exmem_alu_out, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage for the pipelined MIPS core. Adds operand forwarding, a registered EX/MEM pipeline boundary, and an iterative multiply/divide unit with HI/LO registers and a pipeline stall output. Branch resolution is unchanged. Sits between the ID/EX register and the MEM stage, and instantiates the existing `ALU` module for all single-cycle operations.

## Interface
Parameters:
- `MD_STEP`, default 1: result bits per multiply/divide iteration; legal values 1, 2, 4. Latency is N = 32/MD_STEP cycles.
- `HI_LO_RST`, default 0: reset value of HI and LO.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous reset, active-high.
- `id_valid`, input, 1: the ID/EX instruction is real (0 means bubble).
- `flush`, input, 1: squash the current EX instruction.
- `Shamt`, input, 5: shift amount.
- `rs_addr`, `rt_addr`, `rd_addr`, input, 5 each: register addresses.
- `DatabusA`, `DatabusB`, input, 32 each: rs and rt register-file data.
- `Ext_out`, `LU_out`, `PC`, input, 32 each: immediate, LUI-selected operand, instruction PC.
- `ALUSrc1`, `ALUSrc2`, `Sign`, `Branch`, input, 1 each: controls with their existing meaning.
- `ALUFun`, input, 6: ALU function.
- `RegWrite`, `MemRead`, `MemWrite`, input, 1 each: controls passed down the pipeline.
- `MemToReg`, input, 2: control passed down the pipeline.
- `md_op`, input, 4: multiply/divide op. 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; other codes behave as none.
- `mem_RegWrite`, input, 1; `mem_rd`, input, 5; `MEM_ALU_out`, input, 32: EX/MEM forwarding source.
- `wb_RegWrite`, input, 1; `wb_rd`, input, 5; `WB_DatabusC`, input, 32: MEM/WB forwarding source.
- `EX_Branch_EN`, output, 1: branch taken (combinational).
- `ConBA`, output, 32: branch target (combinational).
- `ex_stall`, output, 1: freeze PC, IF/ID and ID/EX (combinational).
- `exmem_valid`, `exmem_RegWrite`, `exmem_MemRead`, `exmem_MemWrite`, output, 1 each: registered pipeline controls.
- `exmem_MemToReg`, output, 2: registered control.
- `exmem_rd`, output, 5: registered destination register.
- `exmem_alu_out`, `exmem_store_data`, `exmem_pc_plus_4`, output, 32 each: registered results.

## Operation
- **Forwarding** applies to rs and rt independently, with priority MEM > WB > register file.
  - The MEM source is used when `mem_RegWrite` is set, `mem_rd` is nonzero, and `mem_rd` equals the source register.
  - The WB source follows the same rule using `wb_RegWrite` and `wb_rd`.
  - Register 0 is never forwarded.
- **ALU operands:**
  - in1 = `ALUSrc1` ? zero-extended `Shamt` : forwarded rs.
  - in2 = `ALUSrc2` ? `LU_out` : forwarded rt.
- **Branch:**
  - `EX_Branch_EN` = `id_valid` & `Branch` & ALU result bit 0 & !`ex_stall`.
  - `ConBA` = `PC` + 4 + (`Ext_out` << 2), truncated to 32 bits.
- **Result mux:** MFHI selects HI, MFLO selects LO; otherwise the ALU result is used. `exmem_store_data` is the forwarded rt.
- **Multiply/divide states:** IDLE, BUSY.
  - In IDLE, an accepted op 1–4 latches the operands and loads counter N-1, then moves to BUSY.
  - In BUSY, the counter decrements once per cycle. At count 0, HI/LO are written and the state returns to IDLE.
  - MULT/MULTU: {HI, LO} = 64-bit signed or unsigned product.
  - DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - Divide by zero: LO = 32'hFFFF_FFFF, HI = dividend. No trap.
  - MTHI/MTLO write the forwarded rs to HI/LO at the EX edge.
- **Stall:** `ex_stall` = `id_valid` & !`flush` & state BUSY & (`md_op` in 1..8).
  - While stalled, the inputs must be held stable upstream.
  - While stalled, the EX/MEM register loads a bubble (all valid and control bits 0).
- **Acceptance:** an instruction is accepted when `id_valid` & !`flush` & !`ex_stall`. Otherwise the EX/MEM register loads a bubble.
- **Flush:**
  - A flush never aborts a multiply/divide already in BUSY.
  - A flushed op is not started.
  - A flushed MTHI/MTLO does not write.

## Timing
- EX/MEM outputs have one-cycle latency.
- A MULT accepted at edge t makes HI/LO valid after edge t+N.
- A dependent MFHI presented at t+1 stalls for cycles t+1 .. t+N and is accepted at edge t+N+1.
- Reset (including mid-operation) forces the following on that edge:
  - state IDLE, counter 0;
  - HI = LO = `HI_LO_RST`;
  - every `exmem_*` output 0.
- Simultaneous completion and a new mul/div request: the request waits one cycle, because the state is still BUSY in the completion cycle.

## Configuration
- `EX_MULDIV_EN` defined: the multiply/divide unit, HI/LO and stall logic are compiled in.
- `EX_MULDIV_EN` undefined:
  - `md_op` is ignored; MFHI/MFLO return 0;
  - `ex_stall` is tied to 0;
  - no HI/LO state exists;
  - forwarding, ALU and branch behaviour are unchanged.

## Test plan
- Forwarding priority:
  - Stimulus: rs_addr=5, mem_rd=5 with MEM_ALU_out=0x11, wb_rd=5 with WB_DatabusC=0x22, ADD with rt=0x1.
  - Response: exmem_alu_out=0x12.
  - Repeat with rs_addr=0: the register-file value is used.
- MULT with MD_STEP=1:
  - Stimulus: rs=0xFFFFFFFF (-1), rt=3, followed by MFHI/MFLO.
  - Response: ex_stall high for 32 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- DIV:
  - Stimulus: -7 / 2.
  - Response: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - Stimulus: DIVU 9 / 0.
  - Response: LO=0xFFFFFFFF, HI=9.
- Branch:
  - Stimulus: PC=0x100, Ext_out=0xFFFFFFFE, Branch=1, ALU result bit0=1.
  - Response: EX_Branch_EN=1, ConBA=0xFC.
  - Same stimulus with flush=1: exmem_valid=0 next cycle.
- Reset mid-operation:
  - Stimulus: reset asserted 5 cycles into a DIVU.
  - Response: next cycle ex_stall=0, HI=LO=0, all exmem_* outputs 0.
  - A subsequent MFLO returns 0 without stalling.
